// File: rtl/delta_decoder_pkg.sv
// Purpose: shared types and default sizes for the delta decoder slice.
//   state_t       - output-stage occupancy (EMPTY: nothing held, FULL: delta held)
//   DEF_BIT_WIDTH - default sum/delta width
//   DEF_CNT_WIDTH - default width of the handed-off sample counter
package delta_decoder_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/delta_decoder_if.sv
// Purpose: valid/ready stream bundle for the delta decoder.
//   in_valid/in_ready/in_data       - running-sum input stream
//   out_valid/out_ready/out_data    - decoded-delta output stream
//   first                           - output is the first sample since reset/clr
// Modports:
//   master - the environment (drives sums, consumes deltas)
//   slave  - the decoder itself
interface delta_decoder_if
  import delta_decoder_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 first;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, first
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, first
  );

endinterface

// File: rtl/delta_decoder_sub.sv
// Purpose: leaf building blocks of the delta decoder.
//   d_ff      - WIDTH-bit register with load enable and synchronous active-low reset
//               ports: clk, rst_n, en, d, q
//   sub_block - combinational Y = A0 - A1 (mod 2^WIDTH, borrow dropped)
//               ports: a0, a1, y

module d_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module sub_block #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] y
);

  // Same-width subtraction naturally wraps modulo 2^WIDTH.
  assign y = a0 - a1;

endmodule

// File: rtl/delta_decoder.sv
// Purpose: recovers increments X[n] = S[n] - S[n-1] from a stream of running
//   sums, with a one-entry registered output stage and a handed-off counter.
// Ports:
//   clk   - clock, all state on posedge
//   rst_n - synchronous active-low reset (beats clr)
//   clr   - synchronous restart: previous sum to 0, held output dropped, count to 0
//   bus   - delta_decoder_if.slave stream bundle (sums in, deltas out, first flag)
//   count - number of deltas handed off (out_valid & out_ready), wraps
module delta_decoder
  import delta_decoder_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  delta_decoder_if.slave       bus,
  output logic [CNT_WIDTH-1:0] count
);

  state_t               state;
  state_t               state_next;
  logic                 out_valid;
  logic                 in_ready;
  logic                 accept;
  logic                 handoff;
  logic                 seen;
  logic                 first_q;
  logic                 prev_en;
  logic [BIT_WIDTH-1:0] prev;
  logic [BIT_WIDTH-1:0] prev_d;
  logic [BIT_WIDTH-1:0] delta;
  logic [BIT_WIDTH-1:0] out_data;

  assign out_valid = (state == FULL);

  // The stage can take a new sum when empty or when its content leaves this
  // cycle; clr blocks acceptance so a restart never swallows a sample.
  assign in_ready = ~clr & (~out_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign handoff  = out_valid & bus.out_ready & ~clr;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.first     = first_q;

  sub_block #(.WIDTH(BIT_WIDTH)) u_sub (
    .a0 (bus.in_data),
    .a1 (prev),
    .y  (delta)
  );

  // prev follows every accepted sum and returns to zero on restart.
  assign prev_en = clr | accept;
  assign prev_d  = clr ? '0 : bus.in_data;

  d_ff #(.WIDTH(BIT_WIDTH)) u_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (prev_en),
    .d     (prev_d),
    .q     (prev)
  );

  d_ff #(.WIDTH(BIT_WIDTH)) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .d     (delta),
    .q     (out_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // In FULL an accept implies out_ready, so drain-and-refill stays FULL.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_next = FULL;
        FULL:    if (bus.out_ready && !accept) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  // first marks the sample decoded against the implicit zero start value.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      seen    <= 1'b0;
      first_q <= 1'b0;
      count   <= '0;
    end else begin
      if (accept) begin
        first_q <= ~seen;
        seen    <= 1'b1;
      end
      if (handoff) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
